// File: rtl/stack_pkg.sv
// stack_pkg: shared op encoding and helpers for the parametrised LIFO stack.
package stack_pkg;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: unreset register array, one sync write port and one async read port.
module stack_regfile #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with show-ahead top, replace-on-push+pop,
// sticky overflow/underflow and a high-water-mark monitor.
module param_stack
  import stack_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic [CNT_W-1:0]  high_water
);
  localparam int AW = clog2(DEPTH);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(DEPTH);
  logic [CNT_W-1:0]  r_count, r_hw, w_next;
  logic              r_ovf, r_udf;
  logic [1:0]        w_op;
  logic              w_full, w_empty, w_we, w_inc, w_dec;
  logic [AW-1:0]     w_waddr, w_raddr;
  logic [DATA_W-1:0] w_rdata;
  assign w_op    = {pop, push};
  assign w_full  = r_count == MAX;
  assign w_empty = r_count == '0;
  assign w_inc   = (w_op == OP_PUSH && !w_full) || (w_op == OP_REPL && w_empty);
  assign w_dec   = w_op == OP_POP && !w_empty;
  assign w_we    = (w_op == OP_PUSH && !w_full) || w_op == OP_REPL;
  assign w_next  = w_inc ? r_count + 1'b1 : w_dec ? r_count - 1'b1 : r_count;
  // Replace on a non-empty stack overwrites the top; otherwise write the next free slot.
  assign w_waddr = AW'((w_op == OP_REPL && !w_empty) ? r_count - 1'b1 : r_count);
  assign w_raddr = AW'(r_count - 1'b1);
  stack_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (din),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      r_count <= '0;
      r_hw    <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_ovf   <= (w_op == OP_PUSH && w_full) || (r_ovf && !clr_err);
      r_udf   <= (w_op == OP_POP && w_empty) || (r_udf && !clr_err);
      r_hw    <= (clr_err || w_next > r_hw) ? w_next : r_hw;
    end
  assign dout       = w_empty ? '0 : w_rdata;
  assign count      = r_count;
  assign empty      = w_empty;
  assign full       = w_full;
  assign overflow   = r_ovf;
  assign underflow  = r_udf;
  assign high_water = r_hw;
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed scenarios for param_stack at DATA_W=8, DEPTH=4.
module tb_param_stack;
  import stack_pkg::*;
  logic       clk = 1'b0, Reset = 1'b1, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [7:0] din = '0, dout;
  logic [2:0] count, high_water;
  logic       empty, full, overflow, underflow;
  logic [17:0] obs;
  int n_cmp = 0, n_err = 0;

  param_stack #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .Reset(Reset), .push(push), .pop(pop), .clr_err(clr_err), .din(din),
    .dout(dout), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .high_water(high_water)
  );

  always #5 clk = ~clk;
  // {count, empty, full, overflow, underflow, high_water, dout}
  assign obs = {count, empty, full, overflow, underflow, high_water, dout};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] d, input logic clr);
    {pop, push} = op;
    din = d;
    clr_err = clr;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (obs !== {3'd0, 4'b1000, 3'd0, 8'h00}) begin n_err++; $display("FAIL reset: got %h expected %h", obs, {3'd0, 4'b1000, 3'd0, 8'h00}); end
    @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic test_push3();
    logic [7:0] v [3];
    v = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      drive(OP_PUSH, v[i], 1'b0);
      tick();
      n_cmp++;
      if (obs !== {3'(i + 1), 4'b0000, 3'(i + 1), v[i]}) begin n_err++; $display("FAIL push%0d: got %h expected %h", i, obs, {3'(i + 1), 4'b0000, 3'(i + 1), v[i]}); end
    end
  endtask

  task automatic test_overflow();
    drive(OP_PUSH, 8'h44, 1'b0);
    tick();
    n_cmp++;
    if (obs !== {3'd4, 4'b0100, 3'd4, 8'h44}) begin n_err++; $display("FAIL fill: got %h expected %h", obs, {3'd4, 4'b0100, 3'd4, 8'h44}); end
    drive(OP_PUSH, 8'h55, 1'b0);
    tick();
    n_cmp++;
    if (obs !== {3'd4, 4'b0110, 3'd4, 8'h44}) begin n_err++; $display("FAIL overflow: got %h expected %h", obs, {3'd4, 4'b0110, 3'd4, 8'h44}); end
    drive(OP_NONE, 8'h00, 1'b1);
    tick();
    n_cmp++;
    if (obs !== {3'd4, 4'b0100, 3'd4, 8'h44}) begin n_err++; $display("FAIL clr_ovf: got %h expected %h", obs, {3'd4, 4'b0100, 3'd4, 8'h44}); end
  endtask

  task automatic test_pop_all();
    logic [7:0] v [4];
    v = '{8'h44, 8'h33, 8'h22, 8'h11};
    drive(OP_POP, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #2;
      n_cmp++;
      if (dout !== v[i]) begin n_err++; $display("FAIL pop%0d_dout: got %h expected %h", i, dout, v[i]); end
      tick();
    end
    n_cmp++;
    if (obs !== {3'd0, 4'b1000, 3'd4, 8'h00}) begin n_err++; $display("FAIL drained: got %h expected %h", obs, {3'd0, 4'b1000, 3'd4, 8'h00}); end
    tick();
    n_cmp++;
    if (obs !== {3'd0, 4'b1001, 3'd4, 8'h00}) begin n_err++; $display("FAIL underflow: got %h expected %h", obs, {3'd0, 4'b1001, 3'd4, 8'h00}); end
  endtask

  task automatic test_replace();
    drive(OP_NONE, 8'h00, 1'b1);
    tick();
    n_cmp++;
    if (obs !== {3'd0, 4'b1000, 3'd0, 8'h00}) begin n_err++; $display("FAIL clr_all: got %h expected %h", obs, {3'd0, 4'b1000, 3'd0, 8'h00}); end
    drive(OP_PUSH, 8'hA1, 1'b0);
    tick();
    drive(OP_PUSH, 8'hB2, 1'b0);
    tick();
    drive(OP_REPL, 8'hC3, 1'b0);
    tick();
    n_cmp++;
    if (obs !== {3'd2, 4'b0000, 3'd2, 8'hC3}) begin n_err++; $display("FAIL replace: got %h expected %h", obs, {3'd2, 4'b0000, 3'd2, 8'hC3}); end
    drive(OP_POP, 8'h00, 1'b0);
    tick();
    n_cmp++;
    if (obs !== {3'd1, 4'b0000, 3'd2, 8'hA1}) begin n_err++; $display("FAIL pop_after_repl: got %h expected %h", obs, {3'd1, 4'b0000, 3'd2, 8'hA1}); end
    tick();
    n_cmp++;
    if (obs !== {3'd0, 4'b1000, 3'd2, 8'h00}) begin n_err++; $display("FAIL pop_to_empty: got %h expected %h", obs, {3'd0, 4'b1000, 3'd2, 8'h00}); end
    drive(OP_REPL, 8'h7E, 1'b0);
    tick();
    n_cmp++;
    if (obs !== {3'd1, 4'b0000, 3'd2, 8'h7E}) begin n_err++; $display("FAIL repl_empty: got %h expected %h", obs, {3'd1, 4'b0000, 3'd2, 8'h7E}); end
  endtask

  task automatic test_set_wins();
    drive(OP_POP, 8'h00, 1'b0);
    tick();
    n_cmp++;
    if (obs !== {3'd0, 4'b1000, 3'd2, 8'h00}) begin n_err++; $display("FAIL pop_7e: got %h expected %h", obs, {3'd0, 4'b1000, 3'd2, 8'h00}); end
    drive(OP_POP, 8'h00, 1'b1);
    tick();
    n_cmp++;
    if (obs !== {3'd0, 4'b1001, 3'd0, 8'h00}) begin n_err++; $display("FAIL set_wins: got %h expected %h", obs, {3'd0, 4'b1001, 3'd0, 8'h00}); end
  endtask

  task automatic test_async_reset();
    logic [7:0] v [3];
    v = '{8'h10, 8'h20, 8'h30};
    for (int i = 0; i < 3; i++) begin
      drive(OP_PUSH, v[i], 1'b0);
      tick();
    end
    n_cmp++;
    if (obs !== {3'd3, 4'b0001, 3'd3, 8'h30}) begin n_err++; $display("FAIL pre_reset: got %h expected %h", obs, {3'd3, 4'b0001, 3'd3, 8'h30}); end
    drive(OP_PUSH, 8'h99, 1'b0);
    #3 Reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== {3'd0, 4'b1000, 3'd0, 8'h00}) begin n_err++; $display("FAIL async_reset: got %h expected %h", obs, {3'd0, 4'b1000, 3'd0, 8'h00}); end
    tick();
    drive(OP_NONE, 8'h00, 1'b0);
    Reset = 1'b0;
    tick();
    n_cmp++;
    if (obs !== {3'd0, 4'b1000, 3'd0, 8'h00}) begin n_err++; $display("FAIL post_reset: got %h expected %h", obs, {3'd0, 4'b1000, 3'd0, 8'h00}); end
    drive(OP_PUSH, 8'h01, 1'b0);
    tick();
    drive(OP_NONE, 8'h00, 1'b0);
    n_cmp++;
    if (obs !== {3'd1, 4'b0000, 3'd1, 8'h01}) begin n_err++; $display("FAIL push_after_reset: got %h expected %h", obs, {3'd1, 4'b0000, 3'd1, 8'h01}); end
  endtask

  initial begin
    test_reset();
    test_push3();
    test_overflow();
    test_pop_all();
    test_replace();
    test_set_wins();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
